irq_controller: RTL and testbench

Parametrised multi-channel interrupt controller for the 16-bit LC-3-style core, replacing the core's single `irq` input and fixed ports 4/5. It synchronises up to 16 interrupt sources, latches edge- or level-mode requests, masks and prioritises them, and drives one `irq` line plus a per-channel handler vector into the core. It supports nested, priority-preemptive service through an in-service register. Software reaches it through the core's I/O port bus.

---
 rtl/irq_controller.sv | 197 +++++++++++++++++++
 tb/tb_irq_controller.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Brief    : Multi-channel interrupt controller for the 16-bit core. Two-flop
//            synchronises each source, latches edge-mode or follows
//            level-mode requests, and masks and prioritises them (channel 0
//            highest). Tracks nested service in an in-service register (ISR)
//            and drives a single irq line plus a handler vector.
// Ports    : clock, reset_n    - clock, asynchronous active-low reset
//            irq_src           - raw asynchronous requests (NUM_IRQ)
//            io_port/io_wdata/ - core I/O bus: address, write data, strobe
//            io_wvalid
//            io_rdata          - combinational read data for io_port
//            irq, irq_vector   - request and handler address to the core
//            irq_ack, eoi      - core takes interrupt / core executes RTI
// Registers: PORT_BASE+0 STATUS(RO) +1 MASK +2 PENDING(W1C) +3 MODE
//            +4 ACTIVE(RO) +5 VBASE
// Revision : 1.0 - initial release
// ============================================================================
module irq_controller #(
    parameter int NUM_IRQ   = 8,
    parameter int PORT_BASE = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [8:0]         io_port,
    input  logic [15:0]        io_wdata,
    input  logic               io_wvalid,
    output logic [15:0]        io_rdata,
    output logic               irq,
    output logic [15:0]        irq_vector,
    input  logic               irq_ack,
    input  logic               eoi
);

    localparam logic [9:0] c_base_lo = 10'(PORT_BASE);
    localparam logic [9:0] c_base_hi = 10'(PORT_BASE + 6);
    localparam logic [8:0] c_base    = 9'(PORT_BASE);

    localparam logic [8:0] c_off_status  = 9'd0;
    localparam logic [8:0] c_off_mask    = 9'd1;
    localparam logic [8:0] c_off_pending = 9'd2;
    localparam logic [8:0] c_off_mode    = 9'd3;
    localparam logic [8:0] c_off_active  = 9'd4;
    localparam logic [8:0] c_off_vbase   = 9'd5;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;
    logic [NUM_IRQ-1:0] r_prev;
    logic [NUM_IRQ-1:0] r_latch;   // edge-mode latched requests
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_mode;    // 1 = rising edge, 0 = level
    logic [NUM_IRQ-1:0] r_isr;
    logic [15:0]        r_vbase;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic               w_in_range;
    logic [8:0]         w_off;
    logic               w_wr_mask;
    logic               w_wr_pend;
    logic               w_wr_mode;
    logic               w_wr_vbase;
    logic [NUM_IRQ-1:0] w_pending;
    logic [NUM_IRQ-1:0] w_req;
    logic               w_req_any;
    logic [3:0]         w_sel;
    logic               w_isr_any;
    logic [3:0]         w_isr_top;
    logic               w_irq;
    logic               w_ack_take;
    logic [NUM_IRQ-1:0] w_ack_onehot;
    logic [NUM_IRQ-1:0] w_eoi_onehot;
    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_latch_nxt;
    logic [NUM_IRQ-1:0] w_isr_nxt;

    // Address decode; the 10-bit compare avoids wrap at the top of the port space.
    assign w_in_range = ({1'b0, io_port} >= c_base_lo) && ({1'b0, io_port} < c_base_hi);
    assign w_off      = io_port - c_base;

    assign w_wr_mask  = io_wvalid && w_in_range && (w_off == c_off_mask);
    assign w_wr_pend  = io_wvalid && w_in_range && (w_off == c_off_pending);
    assign w_wr_mode  = io_wvalid && w_in_range && (w_off == c_off_mode);
    assign w_wr_vbase = io_wvalid && w_in_range && (w_off == c_off_vbase);

    // Level-mode channels expose the synchronised level directly; edge-mode
    // channels expose the latch.
    assign w_pending = (r_mode & r_latch) | (~r_mode & r_sync2);
    assign w_req     = w_pending & r_mask;
    assign w_req_any = |w_req;
    assign w_isr_any = |r_isr;
    assign w_edge    = r_sync2 & ~r_prev;

    // Lowest index wins in both encoders (descending loop, last write wins).
    always_comb begin
        w_sel     = 4'd0;
        w_isr_top = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_sel = 4'(i);
            end
            if (r_isr[i]) begin
                w_isr_top = 4'(i);
            end
        end
    end

    // Preempt only a strictly lower-priority (higher-index) service level.
    assign w_irq      = w_req_any && (!w_isr_any || (w_sel < w_isr_top));
    assign w_ack_take = irq_ack && w_irq;

    always_comb begin
        w_ack_onehot = '0;
        w_eoi_onehot = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_ack_onehot[i] = w_ack_take && (w_sel == 4'(i));
            w_eoi_onehot[i] = eoi && w_isr_any && (w_isr_top == 4'(i));
        end
    end

    assign w_clr = (w_wr_pend ? io_wdata[NUM_IRQ-1:0] : '0) | w_ack_onehot;

    // A fresh edge beats a simultaneous clear. Level-mode channels keep the
    // latch empty, so a switch back to edge mode starts clean.
    always_comb begin
        w_latch_nxt = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (r_mode[i]) begin
                w_latch_nxt[i] = w_edge[i] | (r_latch[i] & ~w_clr[i]);
            end
        end
    end

    // eoi acts on the pre-cycle ISR; the ack bit is then set on top.
    assign w_isr_nxt = (r_isr & ~w_eoi_onehot) | w_ack_onehot;

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_latch <= '0;
            r_mask  <= '0;
            r_mode  <= '0;
            r_isr   <= '0;
            r_vbase <= '0;
        end else begin
            r_sync1 <= irq_src;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_latch <= w_latch_nxt;
            r_isr   <= w_isr_nxt;
            if (w_wr_mask) begin
                r_mask <= io_wdata[NUM_IRQ-1:0];
            end
            if (w_wr_mode) begin
                r_mode <= io_wdata[NUM_IRQ-1:0];
            end
            if (w_wr_vbase) begin
                r_vbase <= io_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign irq        = w_irq;
    assign irq_vector = w_irq ? (r_vbase + {12'd0, w_sel}) : r_vbase;

    always_comb begin
        io_rdata = '0;
        if (w_in_range) begin
            case (w_off)
                c_off_status:  io_rdata[NUM_IRQ-1:0] = w_req;
                c_off_mask:    io_rdata[NUM_IRQ-1:0] = r_mask;
                c_off_pending: io_rdata[NUM_IRQ-1:0] = w_pending;
                c_off_mode:    io_rdata[NUM_IRQ-1:0] = r_mode;
                c_off_active:  io_rdata = {w_isr_any, 11'd0, w_isr_top};
                c_off_vbase:   io_rdata = r_vbase;
                default:       io_rdata = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_controller
// Brief    : Scoreboard bench for irq_controller. Stimulus pushes expected
//            observations into a queue; a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

    localparam int NUM_IRQ = 8;

    localparam logic [8:0] P_STATUS  = 9'd4;
    localparam logic [8:0] P_MASK    = 9'd5;
    localparam logic [8:0] P_PENDING = 9'd6;
    localparam logic [8:0] P_MODE    = 9'd7;
    localparam logic [8:0] P_ACTIVE  = 9'd8;
    localparam logic [8:0] P_VBASE   = 9'd9;

    localparam int K_RD  = 0;
    localparam int K_IRQ = 1;
    localparam int K_VEC = 2;

    logic               clock;
    logic               reset_n;
    logic [NUM_IRQ-1:0] irq_src;
    logic [8:0]         io_port;
    logic [15:0]        io_wdata;
    logic               io_wvalid;
    logic [15:0]        io_rdata;
    logic               irq;
    logic [15:0]        irq_vector;
    logic               irq_ack;
    logic               eoi;

    irq_controller #(.NUM_IRQ(NUM_IRQ), .PORT_BASE(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .irq_src    (irq_src),
        .io_port    (io_port),
        .io_wdata   (io_wdata),
        .io_wvalid  (io_wvalid),
        .io_rdata   (io_rdata),
        .irq        (irq),
        .irq_vector (irq_vector),
        .irq_ack    (irq_ack),
        .eoi        (eoi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor: compares every queued expectation at the falling edge.
    exp_t        m_e;
    always @(negedge clock) begin
        while (q.size() > 0) begin
            m_e = q.pop_front();
            n_tests++;
            case (m_e.kind)
                K_RD: begin
                    if (io_rdata !== m_e.exp) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%04h expected 0x%04h", m_e.name, io_rdata, m_e.exp);
                    end
                end
                K_IRQ: begin
                    if (irq !== m_e.exp[0]) begin
                        n_fail++;
                        $display("FAIL %s: got %0b expected %0b", m_e.name, irq, m_e.exp[0]);
                    end
                end
                default: begin
                    if (irq_vector !== m_e.exp) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%04h expected 0x%04h", m_e.name, irq_vector, m_e.exp);
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [8:0] port, input logic [15:0] data);
        io_port   = port;
        io_wdata  = data;
        io_wvalid = 1'b1;
        tick();
        io_wvalid = 1'b0;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    task automatic expect_val(input int kind, input logic [8:0] port,
                              input logic [15:0] exp, input string name);
        exp_t e;
        if (kind == K_RD) io_port = port;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
        @(negedge clock);
        #1;
    endtask

    task automatic rd(input logic [8:0] port, input logic [15:0] exp, input string name);
        expect_val(K_RD, port, exp, name);
    endtask

    // Edge pulse: 3 edges to latch, then one more with the source low.
    task automatic pulse(input int ch);
        irq_src[ch] = 1'b1;
        ticks(3);
        irq_src[ch] = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        irq_src   = '0;
        io_port   = '0;
        io_wdata  = '0;
        io_wvalid = 1'b0;
        irq_ack   = 1'b0;
        eoi       = 1'b0;
        ticks(3);
        reset_n = 1'b1;
        tick();

        // Reset state
        expect_val(K_IRQ, 9'd0, 16'h0000, "reset_irq");
        expect_val(K_VEC, 9'd0, 16'h0000, "reset_vec");
        rd(P_MASK,   16'h0000, "reset_mask");
        rd(P_ACTIVE, 16'h0000, "reset_active");

        // Single edge, plus out-of-range write and unmapped reads
        wr(P_MASK,  16'h0001);
        wr(P_MODE,  16'h0001);
        wr(P_VBASE, 16'h3000);
        wr(9'd10,   16'hFFFF);
        wr(9'd3,    16'hFFFF);
        rd(P_MASK,  16'h0001, "mask_after_oor_wr");
        rd(9'd10,   16'h0000, "unmapped_10");
        rd(9'd3,    16'h0000, "unmapped_3");
        rd(P_VBASE, 16'h3000, "vbase_rd");
        irq_src[0] = 1'b1;
        ticks(2);
        expect_val(K_IRQ, 9'd0, 16'h0000, "edge_lat_e2");
        irq_src[0] = 1'b0;
        tick();
        expect_val(K_IRQ, 9'd0, 16'h0001, "edge_lat_e3");
        expect_val(K_VEC, 9'd0, 16'h3000, "edge_vec");
        do_ack();
        expect_val(K_IRQ, 9'd0, 16'h0000, "ack_irq_low");
        expect_val(K_VEC, 9'd0, 16'h3000, "idle_vec_vbase");
        rd(P_ACTIVE,  16'h8000, "ack_active");
        rd(P_PENDING, 16'h0000, "ack_clears_pend");
        do_eoi();
        rd(P_ACTIVE,  16'h0000, "eoi_active");

        // Priority and masking
        wr(P_MASK, 16'h000C);
        wr(P_MODE, 16'h000F);
        irq_src[3:1] = 3'b111;
        ticks(3);
        irq_src[3:1] = 3'b000;
        tick();
        expect_val(K_IRQ, 9'd0, 16'h0001, "prio_irq");
        expect_val(K_VEC, 9'd0, 16'h3002, "prio_vec");
        rd(P_STATUS,  16'h000C, "prio_status");
        rd(P_PENDING, 16'h000E, "prio_pending");
        wr(P_PENDING, 16'h000E);
        rd(P_PENDING, 16'h0000, "w1c_all");
        expect_val(K_IRQ, 9'd0, 16'h0000, "w1c_irq_low");

        // Nesting
        wr(P_MASK, 16'h0064);
        wr(P_MODE, 16'h00FF);
        pulse(5);
        expect_val(K_VEC, 9'd0, 16'h3005, "nest_vec5");
        do_ack();
        rd(P_ACTIVE, 16'h8005, "nest_active5");
        pulse(6);
        expect_val(K_IRQ, 9'd0, 16'h0000, "nest_ch6_blocked");
        rd(P_PENDING, 16'h0040, "nest_pend6");
        pulse(2);
        expect_val(K_IRQ, 9'd0, 16'h0001, "nest_ch2_irq");
        expect_val(K_VEC, 9'd0, 16'h3002, "nest_vec2");
        do_ack();
        rd(P_ACTIVE, 16'h8002, "nest_active2");
        expect_val(K_IRQ, 9'd0, 16'h0000, "nest_irq_after_ack2");
        do_eoi();
        rd(P_ACTIVE, 16'h8005, "nest_back_to5");
        expect_val(K_IRQ, 9'd0, 16'h0000, "nest_ch6_still_blocked");
        do_eoi();
        rd(P_ACTIVE, 16'h0000, "nest_isr_empty");
        expect_val(K_VEC, 9'd0, 16'h3006, "nest_vec6");
        do_ack();
        do_eoi();
        rd(P_ACTIVE, 16'h0000, "nest_clean");

        // W1C and collision on ch4 (masked off)
        pulse(4);
        rd(P_PENDING, 16'h0010, "w1c_set");
        wr(P_PENDING, 16'h0010);
        rd(P_PENDING, 16'h0000, "w1c_clear");
        irq_src[4] = 1'b1;
        ticks(2);
        wr(P_PENDING, 16'h0010);
        rd(P_PENDING, 16'h0010, "w1c_collision_set_wins");
        irq_src[4] = 1'b0;
        ticks(3);
        // Edge -> level switch drops the latched bit to the (low) level
        wr(P_MODE, 16'h00EF);
        rd(P_PENDING, 16'h0000, "mode_switch_drop");
        wr(P_MODE, 16'h00FF);
        rd(P_PENDING, 16'h0000, "mode_restore");

        // Level mode on ch7
        wr(P_MODE, 16'h007F);
        wr(P_MASK, 16'h0080);
        irq_src[7] = 1'b1;
        tick();
        expect_val(K_IRQ, 9'd0, 16'h0000, "lvl_e1");
        tick();
        expect_val(K_IRQ, 9'd0, 16'h0001, "lvl_e2");
        expect_val(K_VEC, 9'd0, 16'h3007, "lvl_vec");
        wr(P_PENDING, 16'h0080);
        rd(P_PENDING, 16'h0080, "lvl_w1c_noeffect");
        do_ack();
        expect_val(K_IRQ, 9'd0, 16'h0000, "lvl_acked_quiet");
        do_eoi();
        expect_val(K_IRQ, 9'd0, 16'h0001, "lvl_rerequest");
        irq_src[7] = 1'b0;
        tick();
        expect_val(K_IRQ, 9'd0, 16'h0001, "lvl_fall_e1");
        tick();
        expect_val(K_IRQ, 9'd0, 16'h0000, "lvl_fall_e2");

        // Simultaneous eoi + ack
        wr(P_MODE, 16'h00FF);
        wr(P_MASK, 16'h000A);
        pulse(3);
        do_ack();
        rd(P_ACTIVE, 16'h8003, "sim_active3");
        pulse(1);
        expect_val(K_VEC, 9'd0, 16'h3001, "sim_vec1");
        eoi     = 1'b1;
        irq_ack = 1'b1;
        tick();
        eoi     = 1'b0;
        irq_ack = 1'b0;
        rd(P_ACTIVE, 16'h8001, "sim_active1");
        expect_val(K_IRQ, 9'd0, 16'h0000, "sim_irq_low");
        do_eoi();
        rd(P_ACTIVE, 16'h0000, "sim_clean");

        // Asynchronous reset mid-service
        pulse(3);
        do_ack();
        pulse(1);
        expect_val(K_IRQ, 9'd0, 16'h0001, "pre_reset_irq");
        tick();
        reset_n = 1'b0;
        expect_val(K_IRQ, 9'd0, 16'h0000, "arst_irq");
        expect_val(K_VEC, 9'd0, 16'h0000, "arst_vec");
        for (int p = 4; p <= 9; p++) begin
            rd(9'(p), 16'h0000, $sformatf("arst_port%0d", p));
        end
        tick();
        reset_n = 1'b1;
        ticks(4);
        rd(P_PENDING, 16'h0000, "post_reset_pending");
        rd(P_MODE,    16'h0000, "post_reset_mode");
        expect_val(K_IRQ, 9'd0, 16'h0000, "post_reset_irq");

        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
